// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the pulse/sensor side and the lamp/display side
// of the intersection phase sequencer.
interface traffic_phase_ctrl_if;
   // pulse is a one-cycle qualifier: side_req is latched every cycle, while night
   // and all timing act only in cycles where pulse is high; no back-pressure exists.
   logic       pulse;
   logic       side_req;
   logic       night;
   logic [2:0] main_lamp;
   logic [2:0] side_lamp;
   logic [5:0] sec_left;
   logic [2:0] state;
   logic       phase_done;

   modport master (
      output pulse, side_req, night,
      input  main_lamp, side_lamp, sec_left, state, phase_done
   );

   modport slave (
      input  pulse, side_req, night,
      output main_lamp, side_lamp, sec_left, state, phase_done
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: main/side greens, yellows, all-red clearances and
// a night flashing mode, timed by a 6-bit seconds down-counter.
module traffic_phase_ctrl #(
   parameter int GREEN_MAIN = 10,
   parameter int GREEN_SIDE = 6,
   parameter int YELLOW     = 3,
   parameter int ALL_RED    = 1
) (
   input logic                 clk,
   input logic                 rst,
   traffic_phase_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      MG = 3'd0, MY = 3'd1, RA = 3'd2, SG = 3'd3,
      SY = 3'd4, RB = 3'd5, FL = 3'd6
   } phase_t;

   localparam logic [5:0] GM_L = 6'(GREEN_MAIN);
   localparam logic [5:0] GS_L = 6'(GREEN_SIDE);
   localparam logic [5:0] YL_L = 6'(YELLOW);
   localparam logic [5:0] AR_L = 6'(ALL_RED);

   phase_t     cur;
   logic [5:0] sec_left;
   logic       side_pending;
   logic       flash;
   logic       phase_done;
   logic       last_sec;

   assign last_sec       = (sec_left <= 6'd1);
   assign bus.state      = cur;
   assign bus.sec_left   = sec_left;
   assign bus.phase_done = phase_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur          <= MG;
         sec_left     <= GM_L;
         side_pending <= 1'b0;
         flash        <= 1'b0;
         phase_done   <= 1'b0;
      end else begin
         phase_done <= 1'b0;
         if (bus.side_req) side_pending <= 1'b1;
         case (cur)
            MG: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               // a request arriving with the exit pulse still counts
               else if (side_pending || bus.side_req || bus.night) begin
                  cur <= MY; sec_left <= YL_L; phase_done <= 1'b1;
               end else sec_left <= 6'd0;
            end
            MY: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               else begin cur <= RA; sec_left <= AR_L; phase_done <= 1'b1; end
            end
            RA: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               else if (bus.night) begin
                  cur <= FL; sec_left <= 6'd0; flash <= 1'b1; phase_done <= 1'b1;
               end else begin
                  // clear overrides a same-cycle set from side_req above
                  cur <= SG; sec_left <= GS_L; side_pending <= 1'b0; phase_done <= 1'b1;
               end
            end
            SG: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               else begin cur <= SY; sec_left <= YL_L; phase_done <= 1'b1; end
            end
            SY: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               else begin cur <= RB; sec_left <= AR_L; phase_done <= 1'b1; end
            end
            RB: if (bus.pulse) begin
               if (!last_sec) sec_left <= sec_left - 6'd1;
               else begin cur <= MG; sec_left <= GM_L; phase_done <= 1'b1; end
            end
            FL: if (bus.pulse) begin
               if (bus.night) flash <= ~flash;
               else begin cur <= RB; sec_left <= AR_L; phase_done <= 1'b1; end
            end
            default: begin
               cur <= MG; sec_left <= GM_L; phase_done <= 1'b1;
            end
         endcase
      end
   end

   // lamps are {red, yellow, green}, decoded from registered state only
   always_comb begin
      bus.main_lamp = 3'b100;
      bus.side_lamp = 3'b100;
      case (cur)
         MG: bus.main_lamp = 3'b001;
         MY: bus.main_lamp = 3'b010;
         SG: bus.side_lamp = 3'b001;
         SY: bus.side_lamp = 3'b010;
         FL: begin
            bus.main_lamp = {1'b0, flash, 1'b0};
            bus.side_lamp = {1'b0, flash, 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl, checked every cycle
// against a table-driven phase model.
module tb_traffic_phase_ctrl;
   localparam int GM = 10, GS = 6, YL = 3, AR = 1;

   logic clk = 1'b0;
   logic rst;
   traffic_phase_ctrl_if bus ();

   traffic_phase_ctrl #(
      .GREEN_MAIN(GM), .GREEN_SIDE(GS), .YELLOW(YL), .ALL_RED(AR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // phase tables indexed by state: MG MY RA SG SY RB FL
   int dur_of [7]   = '{GM, YL, AR, GS, YL, AR, 0};
   int next_of [7]  = '{1, 2, 3, 4, 5, 0, 5};
   int main_tab [7] = '{1, 2, 4, 4, 4, 4, 0};
   int side_tab [7] = '{4, 4, 4, 1, 2, 4, 0};

   int m_state, m_sec, done_cnt;
   bit m_pend, m_flash, m_done;
   logic [2:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_enter(input int t);
      m_state = t;
      m_sec   = dur_of[t];
      m_done  = 1'b1;
      if (t == 3) m_pend = 1'b0;
      if (t == 6) m_flash = 1'b1;
      exp_q.push_back(3'(t));
   endtask

   task automatic model_step(input bit p, input bit s, input bit n, input bit r);
      m_done = 1'b0;
      if (r) begin
         m_state = 0; m_sec = GM; m_pend = 1'b0; m_flash = 1'b0;
         exp_q.delete();
         return;
      end
      if (s) m_pend = 1'b1;
      if (!p) return;
      if (m_state == 0) begin
         if (m_sec > 1) m_sec--;
         else if (m_pend || n) model_enter(1);
         else m_sec = 0;
      end else if (m_state == 6) begin
         if (n) m_flash = !m_flash;
         else model_enter(5);
      end else if (m_sec > 1) m_sec--;
      else if (m_state == 2) model_enter(n ? 6 : 3);
      else model_enter(next_of[m_state]);
   endtask

   task automatic check_all();
      check("state", bus.state, m_state);
      check("sec_left", bus.sec_left, m_sec);
      check("main_lamp", bus.main_lamp, (m_state == 6) ? (m_flash ? 2 : 0) : main_tab[m_state]);
      check("side_lamp", bus.side_lamp, (m_state == 6) ? (m_flash ? 2 : 0) : side_tab[m_state]);
      check("phase_done", bus.phase_done, m_done);
      if (bus.phase_done === 1'b1) begin
         if (exp_q.size() == 0) check("done_unexpected", 1, 0);
         else check("done_state", bus.state, exp_q.pop_front());
      end
   endtask

   task automatic cycle(input bit p, input bit s, input bit n, input bit r = 1'b0);
      bus.pulse = p; bus.side_req = s; bus.night = n; rst = r;
      @(posedge clk);
      model_step(p, s, n, r);
      #1;
      check_all();
      if (m_done) done_cnt++;
   endtask

   task automatic pulse_until(input int st, input int max_n, input bit n);
      for (int i = 0; i < max_n; i++) begin
         if (m_state == st) break;
         cycle(1'b1, 1'b0, n);
      end
      check("reach_state", bus.state, st);
   endtask

   initial begin
      int k;
      bit nt;
      int fl_yel [4] = '{2, 0, 2, 0};
      bus.pulse = 1'b0; bus.side_req = 1'b0; bus.night = 1'b0; rst = 1'b1;

      // reset state
      cycle(0, 0, 0, 1);
      check("rst_sec", bus.sec_left, GM);

      // idle hold
      done_cnt = 0;
      repeat (20) begin cycle(1, 0, 0); cycle(0, 0, 0); end
      check("idle_state", bus.state, 0);
      check("idle_sec", bus.sec_left, 0);
      check("idle_done_cnt", done_cnt, 0);

      // full cycle with back-to-back pulses
      cycle(0, 0, 0, 1);
      done_cnt = 0;
      cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 1, 0);
      repeat (22) cycle(1, 0, 0);
      check("full_state", bus.state, 0);
      check("full_sec", bus.sec_left, GM);
      check("full_done_cnt", done_cnt, 6);

      // request on the SG-entry pulse is swallowed
      cycle(0, 1, 0);
      pulse_until(2, 40, 0);
      cycle(1, 1, 0);
      check("latch_sg", bus.state, 3);
      pulse_until(0, 40, 0);
      repeat (12) cycle(1, 0, 0);
      check("latch_no_second", bus.state, 0);
      check("latch_sec0", bus.sec_left, 0);

      // request mid-SG: next MG lasts exactly GREEN_MAIN pulses
      cycle(0, 1, 0);
      pulse_until(3, 40, 0);
      cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 1, 0);
      pulse_until(0, 40, 0);
      k = 0;
      while (m_state == 0 && k < 40) begin cycle(1, 0, 0); k++; end
      check("mg_min_len", k, GM);

      // night mode
      cycle(0, 0, 0, 1);
      repeat (GM) cycle(1, 0, 0);
      check("night_pre_sec", bus.sec_left, 0);
      cycle(1, 0, 1);
      check("night_my", bus.state, 1);
      pulse_until(6, 10, 1);
      for (int i = 0; i < 4; i++) begin
         check("night_yel", bus.main_lamp, fl_yel[i]);
         if (i < 3) cycle(1, 0, 1);
      end
      cycle(0, 0, 0);
      cycle(1, 0, 0);
      check("night_rb", bus.state, 5);
      cycle(1, 0, 0);
      check("night_mg", bus.state, 0);
      check("night_mg_sec", bus.sec_left, GM);

      // reset mid-SG with simultaneous pulse
      cycle(0, 1, 0);
      pulse_until(3, 40, 0);
      cycle(1, 0, 0); cycle(1, 0, 0);
      check("pre_rst_sec", bus.sec_left, 4);
      cycle(1, 0, 0, 1);
      check("rst_mid_state", bus.state, 0);
      check("rst_mid_sec", bus.sec_left, GM);
      check("rst_mid_main", bus.main_lamp, 3'b001);
      check("rst_mid_side", bus.side_lamp, 3'b100);

      // randomized traffic with long pulse-free stretches
      nt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) nt = !nt;
         if ($urandom_range(0, 299) == 0)
            repeat (100) cycle(0, ($urandom_range(0, 9) == 0), nt);
         cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), nt,
               ($urandom_range(0, 799) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
